// File: rtl/multi_bill.sv
`default_nettype none
// ============================================================================
//  Module   : multi_bill
//  Purpose  : Multi-mode laundry billing controller. While waiting for
//             payment it alternates the card balance and the selected price
//             on the display and counts down a payment window. A payment
//             charges the card in signed BCD. An expired window either fines
//             the account every second (FINE) or releases the laundry
//             directly.
//  Options  : `define MULTI_BILL_FINE_EN enables the FINE state. Without it,
//             expiry goes straight to RELEASE and the fine port is ignored.
//  Ports    : clk       system clock
//             rst       asynchronous active-low reset
//             on        power enable, low freezes all state
//             mode      price index into price_tbl
//             price_tbl packed BCD prices, entry k at [k*DIGITS*4 +: DIGITS*4]
//             fine      BCD fine charged per second in FINE
//             bal       BCD card balance
//             pay       single-cycle payment confirm
//             take      single-cycle laundry-taken pulse
//             disp      BCD magnitude shown on the display
//             neg       sign of disp, 1 = debt
//             state_o   one-hot {RELEASE, PAID, WAIT_PAY}, FINE = 000
//             wt_bar    thermometer of remaining payment seconds
//             buzz_en   buzzer enable
//             next      one-cycle pulse on entering RELEASE
//  Revision : 1.0  initial release
// ============================================================================
module multi_bill #(
   parameter int DIGITS        = 3,
   parameter int MODE_W        = 2,
   parameter int TICKS_PER_SEC = 100000000,
   parameter int PAY_SECS      = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              on,
   input  logic [MODE_W-1:0]                 mode,
   input  logic [(2**MODE_W)*DIGITS*4-1:0]   price_tbl,
   input  logic [DIGITS*4-1:0]               fine,
   input  logic [DIGITS*4-1:0]               bal,
   input  logic                              pay,
   input  logic                              take,
   output logic [DIGITS*4-1:0]               disp,
   output logic                              neg,
   output logic [2:0]                        state_o,
   output logic [PAY_SECS-1:0]               wt_bar,
   output logic                              buzz_en,
   output logic                              next
);

   localparam int c_w      = DIGITS * 4;
   localparam int c_modes  = 2 ** MODE_W;
   localparam int c_tick_w = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int c_rot_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(TICKS_PER_SEC - 1);
   localparam logic [c_rot_w-1:0]  c_rot_max  = c_rot_w'(DIGITS - 1);
   localparam logic [c_w-1:0]      c_all9     = {DIGITS{4'h9}};
   localparam logic [c_w-1:0]      c_blank    = {DIGITS{4'hB}};

   typedef enum logic [1:0] {S_WAIT, S_PAID, S_FINE, S_REL} state_t;

   state_t                r_state, w_state_nxt;
   logic [c_tick_w-1:0]   r_tick_cnt;
   logic [3:0]            r_rem, w_rem_nxt;
   logic                  r_show_price, w_show_nxt;
   logic                  r_acct_neg, w_acct_neg_nxt;
   logic [c_w-1:0]        r_acct_mag, w_acct_mag_nxt;
   logic [c_rot_w-1:0]    r_rot, w_rot_nxt;
   logic                  r_expired, w_expired_nxt;
   logic                  r_first, w_first_nxt;
   logic                  r_live;   // low until the first enabled clock after reset
   logic                  w_tick;
   logic [c_w-1:0]        w_price;
   logic [c_w:0]          w_pay_res;
   logic [c_w:0]          w_fine_res;
   logic [PAY_SECS-1:0]   w_therm;
   logic [c_w-1:0]        w_rot_disp;

   // ---------------- BCD helpers ----------------
   function automatic logic [c_w:0] f_add(input logic [c_w-1:0] a, input logic [c_w-1:0] b);
      logic [c_w-1:0] s;
      logic           c;
      logic [4:0]     t;
      s = '0;
      c = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         t = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
         if (t > 5'd9) begin
            t = t + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[i*4 +: 4] = t[3:0];
      end
      return {c, s};
   endfunction

   // a - b, caller guarantees a >= b
   function automatic logic [c_w-1:0] f_sub(input logic [c_w-1:0] a, input logic [c_w-1:0] b);
      logic [c_w-1:0] d;
      logic           br;
      logic [4:0]     t;
      d  = '0;
      br = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         t = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, br};
         if (t[4]) begin
            t  = t + 5'd10;
            br = 1'b1;
         end else begin
            br = 1'b0;
         end
         d[i*4 +: 4] = t[3:0];
      end
      return d;
   endfunction

   // Sign-magnitude (sgn,mag) - x, returns {neg, magnitude}; magnitude
   // saturates at all nines, an exact zero is always positive.
   function automatic logic [c_w:0] f_ssub(input logic sgn, input logic [c_w-1:0] mag,
                                           input logic [c_w-1:0] x);
      logic [c_w:0] s;
      if (sgn) begin
         s = f_add(mag, x);
         return s[c_w] ? {1'b1, c_all9} : {1'b1, s[c_w-1:0]};
      end else if (mag >= x) begin
         return {1'b0, f_sub(mag, x)};
      end else begin
         return {1'b1, f_sub(x, mag)};
      end
   endfunction

   // ---------------- datapath helpers ----------------
   always_comb begin
      w_price = '0;
      for (int k = 0; k < c_modes; k++) begin
         if (mode == MODE_W'(k)) w_price = price_tbl[k*c_w +: c_w];
      end
   end

   always_comb begin
      w_therm = '0;
      for (int i = 0; i < PAY_SECS; i++) w_therm[i] = (i < int'(r_rem));
   end

   always_comb begin
      w_rot_disp = c_blank;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_rot == c_rot_w'(d)) w_rot_disp[d*4 +: 4] = 4'h8;
      end
   end

   assign w_tick     = (r_tick_cnt == c_tick_max);
   assign w_pay_res  = f_ssub(r_state == S_WAIT ? 1'b0 : r_acct_neg,
                              r_state == S_WAIT ? bal  : r_acct_mag, w_price);

`ifdef MULTI_BILL_FINE_EN
   assign w_fine_res = f_ssub(r_acct_neg, r_acct_mag, fine);
`else
   logic w_unused_fine;
   assign w_unused_fine = ^fine;
   assign w_fine_res    = {r_acct_neg, r_acct_mag};
`endif

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt    = r_state;
      w_rem_nxt      = r_rem;
      w_show_nxt     = r_show_price;
      w_acct_neg_nxt = r_acct_neg;
      w_acct_mag_nxt = r_acct_mag;
      w_rot_nxt      = r_rot;
      w_expired_nxt  = r_expired;
      w_first_nxt    = 1'b0;
      unique case (r_state)
         S_WAIT: begin
            // payment takes priority over a simultaneous expiry
            if (pay) begin
               w_state_nxt    = S_PAID;
               w_acct_neg_nxt = w_pay_res[c_w];
               w_acct_mag_nxt = w_pay_res[c_w-1:0];
            end else if (w_tick) begin
               w_rem_nxt  = r_rem - 4'd1;
               w_show_nxt = ~r_show_price;
               if (r_rem <= 4'd1) begin
                  w_expired_nxt  = 1'b1;
                  w_acct_neg_nxt = 1'b0;
                  w_acct_mag_nxt = bal;
`ifdef MULTI_BILL_FINE_EN
                  w_state_nxt    = S_FINE;
`else
                  w_state_nxt    = S_REL;
                  w_first_nxt    = 1'b1;
`endif
               end
            end
         end
         S_PAID: begin
            if (take) begin
               w_state_nxt = S_REL;
               w_first_nxt = 1'b1;
            end
         end
         S_FINE: begin
            if (pay) begin
               w_state_nxt    = S_PAID;
               w_acct_neg_nxt = w_pay_res[c_w];
               w_acct_mag_nxt = w_pay_res[c_w-1:0];
            end else if (w_tick) begin
               w_acct_neg_nxt = w_fine_res[c_w];
               w_acct_mag_nxt = w_fine_res[c_w-1:0];
            end
         end
         default: begin // S_REL: rotate the marker digit once per second
            if (w_tick) w_rot_nxt = (r_rot == c_rot_max) ? '0 : r_rot + 1'b1;
         end
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_WAIT;
         r_tick_cnt   <= '0;
         r_rem        <= 4'(PAY_SECS);
         r_show_price <= 1'b0;
         r_acct_neg   <= 1'b0;
         r_acct_mag   <= '0;
         r_rot        <= '0;
         r_expired    <= 1'b0;
         r_first      <= 1'b0;
         r_live       <= 1'b0;
      end else if (on) begin
         r_state      <= w_state_nxt;
         r_tick_cnt   <= (w_state_nxt != r_state || w_tick) ? '0 : r_tick_cnt + 1'b1;
         r_rem        <= w_rem_nxt;
         r_show_price <= w_show_nxt;
         r_acct_neg   <= w_acct_neg_nxt;
         r_acct_mag   <= w_acct_mag_nxt;
         r_rot        <= w_rot_nxt;
         r_expired    <= w_expired_nxt;
         r_first      <= w_first_nxt;
         r_live       <= 1'b1;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      unique case (r_state)
         S_WAIT:  state_o = 3'b001;
         S_PAID:  state_o = 3'b010;
         S_REL:   state_o = 3'b100;
         default: state_o = 3'b000;
      endcase
   end

   always_comb begin
      disp    = c_blank;
      neg     = 1'b0;
      buzz_en = 1'b0;
      next    = 1'b0;
      wt_bar  = '1;
      if (r_live) begin
         unique case (r_state)
            S_WAIT: begin
               buzz_en = 1'b1;
               disp    = r_show_price ? w_price : bal;
               wt_bar  = w_therm;
            end
            S_PAID: begin
               disp   = r_acct_mag;
               neg    = r_acct_neg;
               wt_bar = r_expired ? '0 : '1;
            end
            S_FINE: begin
               disp   = r_acct_mag;
               neg    = r_acct_neg;
               wt_bar = '0;
            end
            default: begin
               disp   = w_rot_disp;
               next   = r_first;
               wt_bar = r_expired ? '0 : '1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
